// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: controller states and default datapath width.
package arith_pkg;

    localparam int SERIAL_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder cell written at gate level; c_out is the majority of the three inputs.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    logic ab_x;
    logic ab_a;
    logic xc_a;

    assign ab_x  = a ^ b;
    assign ab_a  = a & b;
    assign xc_a  = ab_x & c_in;
    assign s     = ab_x ^ c_in;
    assign c_out = ab_a | xc_a;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder reusing one full_adder_cell over WIDTH cycles.
// Define SERIAL_ADDER_OVF_EN to add a registered signed-overflow output.
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             co;

    full_adder_cell u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c_in  (carry),
        .s     (s),
        .c_out (co)
    );

    // Result bits enter at the MSB, so after WIDTH shifts bit 0 is the LSB.
    assign res_nxt = {s, res_sr};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= c_in;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= co;
                    res_sr <= res_nxt[WIDTH-1:1];
                    cnt    <= cnt + CW'(1);
                    // Final bit: publish straight from the adder so sum is valid with done.
                    if (cnt == LAST) begin
                        sum       <= res_nxt;
                        carry_out <= co;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the last bit, carry holds the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (state == RUN && cnt == LAST)
            overflow <= carry ^ co;
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8) with hand-computed sums; covers SERIAL_ADDER_OVF_EN when defined.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic         overflow;
`endif

    int checks = 0;
    int failures = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept an operation, count edges to done, check the result, then return to IDLE.
    task automatic run_add(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic ci, input logic [W-1:0] s_exp, input logic co_exp);
        int n;
        a = av; b = bv; c_in = ci; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~av; b = ~bv; c_in = ~ci;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(W));
        chk({tag, "_sum"}, 32'(sum), 32'(s_exp));
        chk({tag, "_cout"}, 32'(carry_out), 32'(co_exp));
        tick();
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int ndone;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_state", {28'd0, busy, done, carry_out, 1'b0}, 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", 32'(overflow), 32'd0);
`endif

        run_add("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run_add("wrap1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_add("wrap2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Back-to-back: start in the first IDLE cycle after done; prior sum still held.
        chk("b2b_hold", 32'(sum), 32'h00FF);
        run_add("b2b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

        // Start while busy is ignored.
        a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'hAA; b = 8'h55; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                ndone++;
                chk("busy_sum", 32'(sum), 32'h30);
            end
            tick();
        end
        chk("busy_ndone", 32'(ndone), 32'd1);

        // Reset mid-operation at cnt=3.
        a = 8'hC3; b = 8'h3C; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_flags", {29'd0, busy, done, carry_out}, 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("mid_rst_nodone", 32'(ndone), 32'd0);
        run_add("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

`ifdef SERIAL_ADDER_OVF_EN
        run_add("ovf1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        chk("ovf1_ovf", 32'(overflow), 32'd1);
        run_add("ovf2", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1);
        chk("ovf2_ovf", 32'(overflow), 32'd1);
        run_add("ovf3", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
        chk("ovf3_ovf", 32'(overflow), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
